// File: rtl/gmii_xgmii_packer_pkg.sv
// gmii_xgmii_packer_pkg: XGMII control codes, FSM/word-kind enums and the per-lane termination helper
package gmii_xgmii_packer_pkg;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  typedef enum logic [2:0] {SYNC, IDLE, DATA, TERM, DISCARD} state_t;
  typedef enum logic [1:0] {K_DATA, K_END_OK, K_END_ERR, K_DROP} kind_t;
  function automatic logic [8:0] term_lane(input int i, input int p, input logic err, input logic [8:0] cur);
    return i < p ? cur :
           i == p ? {1'b1, err ? XGMII_ERROR : XGMII_TERM} :
           (err && i == p + 1) ? {1'b1, XGMII_TERM} : {1'b1, XGMII_IDLE};
  endfunction
endpackage

// File: rtl/gmii_xgmii_packer_term_gen.sv
// xgmii_term_gen: builds the /T/ or /E//T/ word from a partial word and the termination lane
module xgmii_term_gen
  import gmii_xgmii_packer_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic [8*LANES-1:0]         part_d,
  input  logic [LANES-1:0]           part_c,
  input  logic [$clog2(LANES)-1:0]   lane,
  input  logic                       err,
  output logic [8*LANES-1:0]         word,
  output logic [LANES-1:0]           ctrl,
  output logic                       two
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign {ctrl[i], word[8*i+:8]} = term_lane(i, int'(lane), err, {part_c[i], part_d[8*i+:8]});
  end
  assign two = err & (&lane);
endmodule

// File: rtl/gmii_xgmii_packer.sv
// gmii_xgmii_packer: packs GMII receive bytes into XGMII words with framing, back-pressure and stats
module gmii_xgmii_packer
  import gmii_xgmii_packer_pkg::*;
#(
  parameter int LANES = 8,
  parameter int FRAME_MAX_BIT_WIDTH = 11,
  parameter int CNT_W = 32
) (
  input  logic                 gmii_clk,
  input  logic                 sys_rst,
  input  logic                 gmii_dv,
  input  logic                 gmii_er,
  input  logic [7:0]           gmii_rxd,
  input  logic                 xgmii_full,
  output logic                 xgmii_wr_en,
  output logic [LANES-1:0]     xgmii_rxc,
  output logic [8*LANES-1:0]   xgmii_rxd,
  output logic [CNT_W-1:0]     stat_frames,
  output logic [CNT_W-1:0]     stat_errors,
  output logic [CNT_W-1:0]     stat_drops
);
  localparam int LW = $clog2(LANES);
  localparam int FW = FRAME_MAX_BIT_WIDTH;
  localparam logic [8*LANES-1:0] IDLE_WORD = {LANES{XGMII_IDLE}};
  localparam logic [8*LANES-1:0] SEC_WORD  = {{(LANES-1){XGMII_IDLE}}, XGMII_TERM};
  localparam logic [8*LANES-1:0] DROP_WORD = {{(LANES-2){XGMII_IDLE}}, XGMII_TERM, XGMII_ERROR};
  state_t state, state_n;
  kind_t kind, kind_n;
  logic [FW-1:0] cnt, cnt_n;
  logic err, err_n, drop, drop_n, nf, nf_n, sec, sec_n, pend, pend_n;
  logic [8*LANES-1:0] acc_d, acc_d_n, rxd_n, t_word;
  logic [LANES-1:0] acc_c, acc_c_n, rxc_n, t_ctrl;
  logic t_two, fail, wr_ok;
  logic [LW-1:0] lane;
  assign lane = cnt[LW-1:0];
  assign wr_ok = pend & ~xgmii_full;
  // a blocked TERM word just waits; any other blocked word loses the frame
  assign fail = pend & xgmii_full & (kind != K_DROP);
  assign xgmii_wr_en = wr_ok;
  xgmii_term_gen #(.LANES(LANES)) u_term (
    .part_d(acc_d), .part_c(acc_c), .lane(lane), .err(err | gmii_dv),
    .word(t_word), .ctrl(t_ctrl), .two(t_two)
  );
  always_comb begin
    state_n = state;
    kind_n = kind;
    cnt_n = cnt;
    err_n = err;
    drop_n = drop;
    nf_n = nf;
    sec_n = 1'b0;
    pend_n = 1'b0;
    acc_d_n = acc_d;
    acc_c_n = acc_c;
    rxd_n = xgmii_rxd;
    rxc_n = xgmii_rxc;
    if (sec) begin
      rxd_n = SEC_WORD;
      rxc_n = '1;
      pend_n = 1'b1;
      kind_n = K_END_ERR;
    end
    case (state)
      SYNC: if (!gmii_dv) state_n = IDLE;
      IDLE: if (gmii_dv) begin
        state_n = DATA;
        cnt_n = FW'(1);
        err_n = gmii_er;
        acc_d_n[7:0] = XGMII_START;
        acc_c_n = LANES'(1);
      end
      DATA: if (!gmii_dv || cnt == {FW{1'b1}}) begin
        rxd_n = t_word;
        rxc_n = t_ctrl;
        pend_n = 1'b1;
        kind_n = (err | gmii_dv) ? K_END_ERR : K_END_OK;
        sec_n = t_two;
        state_n = gmii_dv ? DISCARD : IDLE;
        drop_n = 1'b0;
      end else begin
        acc_d_n[8*lane+:8] = gmii_er ? XGMII_ERROR : gmii_rxd;
        acc_c_n[lane] = gmii_er;
        err_n = err | gmii_er;
        cnt_n = cnt + FW'(1);
        if (&lane) begin
          rxd_n = acc_d_n;
          rxc_n = acc_c_n;
          pend_n = 1'b1;
          kind_n = K_DATA;
        end
      end
      DISCARD: if (!gmii_dv) state_n = drop ? TERM : IDLE;
      TERM: begin
        nf_n = nf | gmii_dv;
        if (!xgmii_full) begin
          state_n = (nf | gmii_dv) ? DISCARD : IDLE;
          drop_n = 1'b0;
          nf_n = 1'b0;
        end
      end
      default: state_n = SYNC;
    endcase
    if (fail) begin
      state_n = (kind == K_DATA && gmii_dv) ? DISCARD : TERM;
      drop_n = 1'b1;
      nf_n = 1'b0;
      sec_n = 1'b0;
      pend_n = 1'b0;
    end
    if (state_n == TERM) begin
      rxd_n = DROP_WORD;
      rxc_n = '1;
      pend_n = 1'b1;
      kind_n = K_DROP;
    end
  end
  always_ff @(posedge gmii_clk) begin
    if (sys_rst) begin
      state <= SYNC;
      kind <= K_DATA;
      cnt <= '0;
      err <= 1'b0;
      drop <= 1'b0;
      nf <= 1'b0;
      sec <= 1'b0;
      pend <= 1'b0;
      acc_d <= IDLE_WORD;
      acc_c <= '1;
      xgmii_rxd <= IDLE_WORD;
      xgmii_rxc <= '1;
      stat_frames <= '0;
      stat_errors <= '0;
      stat_drops <= '0;
    end else begin
      state <= state_n;
      kind <= kind_n;
      cnt <= cnt_n;
      err <= err_n;
      drop <= drop_n;
      nf <= nf_n;
      sec <= sec_n;
      pend <= pend_n;
      acc_d <= acc_d_n;
      acc_c <= acc_c_n;
      xgmii_rxd <= rxd_n;
      xgmii_rxc <= rxc_n;
      if (wr_ok && !sec && kind == K_END_OK) stat_frames <= stat_frames + CNT_W'(1);
      if (wr_ok && !sec && kind == K_END_ERR) stat_errors <= stat_errors + CNT_W'(1);
      if (wr_ok && kind == K_DROP) stat_drops <= stat_drops + ((nf | gmii_dv) ? CNT_W'(2) : CNT_W'(1));
    end
  end
endmodule

// File: tb/tb_gmii_xgmii_packer.sv
// tb_gmii_xgmii_packer: scoreboard bench over 8-lane, 4-lane and short-max-frame packer instances
module tb_gmii_xgmii_packer;
  typedef struct packed {logic [63:0] d; logic [7:0] c;} word_t;
  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  logic gmii_dv = 1'b0;
  logic gmii_er = 1'b0;
  logic [7:0] gmii_rxd = 8'h00;
  logic full = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [2:0] dv_g, full_g;
  logic wr8, wr4, wr6, m_wr;
  logic [63:0] rxd8, rxd6, m_rxd;
  logic [31:0] rxd4;
  logic [7:0] rxc8, rxc6, m_rxc;
  logic [3:0] rxc4;
  logic [31:0] frames8, errors8, drops8, frames4, errors4, drops4, frames6, errors6, drops6;
  int n_checks = 0;
  int n_pass = 0;
  word_t exp_q[$];

  assign dv_g = gmii_dv ? (3'b001 << sel) : 3'b000;
  assign full_g = full ? (3'b001 << sel) : 3'b000;
  assign m_wr = sel == 2'd0 ? wr8 : sel == 2'd1 ? wr4 : wr6;
  assign m_rxd = sel == 2'd0 ? rxd8 : sel == 2'd1 ? {32'h0, rxd4} : rxd6;
  assign m_rxc = sel == 2'd0 ? rxc8 : sel == 2'd1 ? {4'h0, rxc4} : rxc6;

  gmii_xgmii_packer #(.LANES(8), .FRAME_MAX_BIT_WIDTH(11), .CNT_W(32)) dut (
    .gmii_clk(clk), .sys_rst(sys_rst), .gmii_dv(dv_g[0]), .gmii_er(gmii_er), .gmii_rxd(gmii_rxd),
    .xgmii_full(full_g[0]), .xgmii_wr_en(wr8), .xgmii_rxc(rxc8), .xgmii_rxd(rxd8),
    .stat_frames(frames8), .stat_errors(errors8), .stat_drops(drops8));
  gmii_xgmii_packer #(.LANES(4), .FRAME_MAX_BIT_WIDTH(11), .CNT_W(32)) dut4 (
    .gmii_clk(clk), .sys_rst(sys_rst), .gmii_dv(dv_g[1]), .gmii_er(gmii_er), .gmii_rxd(gmii_rxd),
    .xgmii_full(full_g[1]), .xgmii_wr_en(wr4), .xgmii_rxc(rxc4), .xgmii_rxd(rxd4),
    .stat_frames(frames4), .stat_errors(errors4), .stat_drops(drops4));
  gmii_xgmii_packer #(.LANES(8), .FRAME_MAX_BIT_WIDTH(6), .CNT_W(32)) dut6 (
    .gmii_clk(clk), .sys_rst(sys_rst), .gmii_dv(dv_g[2]), .gmii_er(gmii_er), .gmii_rxd(gmii_rxd),
    .xgmii_full(full_g[2]), .xgmii_wr_en(wr6), .xgmii_rxc(rxc6), .xgmii_rxd(rxd6),
    .stat_frames(frames6), .stat_errors(errors6), .stat_drops(drops6));

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 11);
  endfunction

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    gmii_dv = dv;
    gmii_er = er;
    gmii_rxd = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input int len, input int er_byte);
    for (int i = 0; i < len; i++) drive(1'b1, i + 1 == er_byte, pat(i));
    drive(1'b0, 1'b0, 8'h00);
  endtask

  // byte-stream model: symbols S,data..,[E],T then idle padding, chopped into words
  task automatic expect_frame(input int lanes, input int len, input int er_byte, input int maxb);
    logic [8:0] sym[$];
    logic bad;
    word_t x;
    int n;
    n = len > maxb ? maxb : len;
    bad = len > maxb;
    for (int i = 0; i < n; i++) begin
      if (i == 0) sym.push_back(9'h1FB);
      else if (i + 1 == er_byte) begin
        sym.push_back(9'h1FE);
        bad = 1'b1;
      end else sym.push_back({1'b0, pat(i)});
    end
    if (bad) sym.push_back(9'h1FE);
    sym.push_back(9'h1FD);
    while (sym.size() % lanes != 0) sym.push_back(9'h107);
    for (int w = 0; w < sym.size() / lanes; w++) begin
      x = '0;
      for (int l = 0; l < lanes; l++) begin
        x.d[8*l+:8] = sym[w*lanes+l][7:0];
        x.c[l] = sym[w*lanes+l][8];
      end
      exp_q.push_back(x);
    end
  endtask

  task automatic monitor();
    word_t e;
    forever begin
      @(negedge clk);
      if (m_wr === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL unexpected_write: got rxd=%h rxc=%h, required no write", m_rxd, m_rxc);
        else begin
          e = exp_q.pop_front();
          if (m_rxd !== e.d || m_rxc !== e.c)
            $display("FAIL word: got rxd=%h rxc=%h, required rxd=%h rxc=%h", m_rxd, m_rxc, e.d, e.c);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (wr8 !== 1'b0) $display("FAIL reset_wr_en: got %b required 0", wr8); else n_pass++;
    n_checks++; if (rxc8 !== 8'hff) $display("FAIL reset_rxc: got %h required ff", rxc8); else n_pass++;
    n_checks++; if (rxd8 !== 64'h0707070707070707) $display("FAIL reset_rxd: got %h required 0707070707070707", rxd8); else n_pass++;
    n_checks++; if (frames8 !== 32'd0) $display("FAIL reset_frames: got %0d required 0", frames8); else n_pass++;
    n_checks++; if (errors8 !== 32'd0) $display("FAIL reset_errors: got %0d required 0", errors8); else n_pass++;
    n_checks++; if (drops8 !== 32'd0) $display("FAIL reset_drops: got %0d required 0", drops8); else n_pass++;
    @(posedge clk);
    #1;
    sys_rst = 1'b0;
    idle(2);
  endtask

  task automatic test_frame64();
    sel = 2'd0;
    expect_frame(8, 64, 0, 2047);
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b0, pat(i));
      if (i == 6) begin
        n_checks++; if (m_wr !== 1'b0) $display("FAIL early_write: got %b required 0", m_wr); else n_pass++;
      end
      if (i == 7) begin
        n_checks++; if (m_wr !== 1'b1) $display("FAIL word_latency: got %b required 1", m_wr); else n_pass++;
      end
    end
    drive(1'b0, 1'b0, 8'h00);
    n_checks++; if (m_wr !== 1'b1) $display("FAIL term_latency: got %b required 1", m_wr); else n_pass++;
    idle(4);
    n_checks++; if (exp_q.size() != 0) $display("FAIL drain64: got %0d left required 0", exp_q.size()); else n_pass++;
    n_checks++; if (frames8 !== 32'd1) $display("FAIL frames64: got %0d required 1", frames8); else n_pass++;
  endtask

  task automatic test_frame61();
    sel = 2'd0;
    expect_frame(8, 61, 0, 2047);
    send_frame(61, 0);
    idle(4);
    n_checks++; if (exp_q.size() != 0) $display("FAIL drain61: got %0d left required 0", exp_q.size()); else n_pass++;
    n_checks++; if (frames8 !== 32'd2) $display("FAIL frames61: got %0d required 2", frames8); else n_pass++;
  endtask

  task automatic test_error_lanes4();
    sel = 2'd1;
    expect_frame(4, 10, 6, 2047);
    send_frame(10, 6);
    idle(4);
    n_checks++; if (exp_q.size() != 0) $display("FAIL drain_err4: got %0d left required 0", exp_q.size()); else n_pass++;
    n_checks++; if (errors4 !== 32'd1) $display("FAIL errors4: got %0d required 1", errors4); else n_pass++;
    n_checks++; if (frames4 !== 32'd0) $display("FAIL frames4: got %0d required 0", frames4); else n_pass++;
  endtask

  task automatic test_backpressure();
    word_t x;
    sel = 2'd0;
    expect_frame(8, 64, 0, 2047);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    x.d = 64'h070707070707fdfe;
    x.c = 8'hff;
    exp_q.push_back(x);
    for (int i = 0; i < 64; i++) begin
      full = i >= 20;
      drive(1'b1, 1'b0, pat(i));
    end
    full = 1'b1;
    idle(3);
    full = 1'b0;
    idle(4);
    n_checks++; if (exp_q.size() != 0) $display("FAIL drain_bp: got %0d left required 0", exp_q.size()); else n_pass++;
    n_checks++; if (drops8 !== 32'd1) $display("FAIL drops_bp: got %0d required 1", drops8); else n_pass++;
    n_checks++; if (frames8 !== 32'd2) $display("FAIL frames_bp: got %0d required 2", frames8); else n_pass++;
    n_checks++; if (errors8 !== 32'd0) $display("FAIL errors_bp: got %0d required 0", errors8); else n_pass++;
  endtask

  task automatic test_oversize();
    sel = 2'd2;
    expect_frame(8, 80, 0, 63);
    send_frame(80, 0);
    idle(4);
    n_checks++; if (exp_q.size() != 0) $display("FAIL drain_over: got %0d left required 0", exp_q.size()); else n_pass++;
    n_checks++; if (errors6 !== 32'd1) $display("FAIL errors_over: got %0d required 1", errors6); else n_pass++;
    n_checks++; if (frames6 !== 32'd0) $display("FAIL frames_over: got %0d required 0", frames6); else n_pass++;
  endtask

  task automatic test_back_to_back();
    sel = 2'd0;
    expect_frame(8, 15, 3, 2047);
    expect_frame(8, 9, 0, 2047);
    send_frame(15, 3);
    send_frame(9, 0);
    idle(4);
    n_checks++; if (exp_q.size() != 0) $display("FAIL drain_b2b: got %0d left required 0", exp_q.size()); else n_pass++;
    n_checks++; if (frames8 !== 32'd3) $display("FAIL frames_b2b: got %0d required 3", frames8); else n_pass++;
    n_checks++; if (errors8 !== 32'd1) $display("FAIL errors_b2b: got %0d required 1", errors8); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    sel = 2'd0;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, pat(i));
    sys_rst = 1'b1;
    drive(1'b1, 1'b0, pat(5));
    drive(1'b1, 1'b0, pat(6));
    sys_rst = 1'b0;
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, pat(i + 7));
    idle(2);
    expect_frame(8, 16, 0, 2047);
    send_frame(16, 0);
    idle(4);
    n_checks++; if (exp_q.size() != 0) $display("FAIL drain_rst: got %0d left required 0", exp_q.size()); else n_pass++;
    n_checks++; if (frames8 !== 32'd1) $display("FAIL frames_rst: got %0d required 1", frames8); else n_pass++;
    n_checks++; if (errors8 !== 32'd0) $display("FAIL errors_rst: got %0d required 0", errors8); else n_pass++;
    n_checks++; if (drops8 !== 32'd0) $display("FAIL drops_rst: got %0d required 0", drops8); else n_pass++;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_frame64();
    test_frame61();
    test_error_lanes4();
    test_backpressure();
    test_oversize();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/gmii_xgmii_packer.md
# gmii_xgmii_packer

Single-clock GMII-to-XGMII byte packer for the receive path. It collects 8-bit GMII bytes into LANES-wide XGMII words with per-lane control bits. It inserts /S/, /T/, /E/ and idle codes, and writes each completed word to a downstream write-side FIFO port. Compared with the earlier fixed 64-bit converter, it supports 32- or 64-bit words, a termination at any lane, GMII error propagation, FIFO back-pressure handling, oversize truncation and frame statistics.

## Interface
- LANES, 8, bytes per output word; legal values 4 or 8.
- FRAME_MAX_BIT_WIDTH, 11, byte-counter width; max frame = 2^FRAME_MAX_BIT_WIDTH-1 bytes.
- CNT_W, 32, width of each statistics counter.
- gmii_clk  in  1  sole clock; all logic on rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- gmii_dv  in  1  GMII data valid.
- gmii_er  in  1  GMII receive error; qualified by gmii_dv.
- gmii_rxd  in  8  GMII byte.
- xgmii_full  in  1  downstream FIFO full.
- xgmii_wr_en  out  1  write strobe; one word per asserted cycle.
- xgmii_rxc  out  LANES  control bit per lane; lane i = bit i.
- xgmii_rxd  out  8*LANES  lane i = bits [8i+7:8i]; lane 0 is earliest in time.
- stat_frames  out  CNT_W  frames terminated cleanly.
- stat_errors  out  CNT_W  frames terminated with /E/ (gmii_er or oversize).
- stat_drops  out  CNT_W  frames lost or cut due to xgmii_full.

## Operation
- States: SYNC (reset state), IDLE, DATA, TERM, DISCARD.
- SYNC: ignore input; go to IDLE on the first cycle with gmii_dv=0. A frame that is in progress across reset is never emitted.
- IDLE, gmii_dv=1: the first byte is replaced by /S/, placed in lane 0 as 0xFB with ctrl=1. Byte count becomes 1. Go to DATA.
- DATA, gmii_dv=1:
  - Place the byte at lane count mod LANES, with ctrl=0 and data=gmii_rxd.
  - If gmii_er=1, the byte becomes /E/ (0xFE, ctrl=1) and an error-flag is set.
  - When lane LANES-1 is filled, the word is written.
- DATA, gmii_dv=0 (termination):
  - Lane p = count mod LANES gets /T/ (0xFD, ctrl=1); lanes above p get 0x07 with ctrl=1.
  - If p=0, this is a fresh all-control word.
  - If the error-flag is set, the /T/ word carries an /E/ at lane p and the /T/ moves to lane p+1. If p=LANES-1, /E/ ends that word and a following word holds /T/ at lane 0.
  - Increment stat_frames or stat_errors, then return to IDLE.
- Oversize: when count reaches 2^FRAME_MAX_BIT_WIDTH-1 and gmii_dv is still 1, terminate as an error (as above). Then enter DISCARD until gmii_dv=0.
- Back-pressure:
  - A data-word write attempted while xgmii_full=1 is not performed.
  - The frame is marked dropped and the state becomes DISCARD.
  - When gmii_dv falls, go to TERM.
  - TERM holds a word with /E/ at lane 0, /T/ at lane 1 and idles above. It writes that word on the first cycle with xgmii_full=0, increments stat_drops, then goes to IDLE.
- If gmii_dv rises while in TERM, that new frame is discarded entirely: go to DISCARD after the TERM write. stat_drops is incremented once more.
- Termination words written while xgmii_full=0 follow normal rules. A termination needing two words and hitting full on the second word also follows the TERM path.
- Statistics counters wrap modulo 2^CNT_W.

## Timing
- Reset values:
  - xgmii_wr_en=0.
  - xgmii_rxc={LANES{1'b1}}.
  - xgmii_rxd = all lanes 0x07.
  - stat_* = 0.
  - state = SYNC.
- Word latency: xgmii_wr_en asserts on the cycle after the byte that completes the word is sampled. Data and control are registered and valid only while xgmii_wr_en=1.
- Termination: gmii_dv low in cycle k → xgmii_wr_en in cycle k+1. A two-word termination writes in k+1 and k+2.
- Sustained rate: at most one write every LANES cycles during data, plus termination writes.
- xgmii_full is sampled in the same cycle as the intended write; no write occurs while it is 1.

## Structure
- A shared package holds the XGMII code constants (IDLE 0x07, START 0xFB, TERM 0xFD, ERROR 0xFE), the state enum, and a LANES-generic helper that builds a termination word from the lane position and error flag.
- One sub-module, xgmii_term_gen, is natural: a combinational termination-word builder (partial word, lane index, error flag → word, ctrl, needs_second_word).
- Statistics counters stay inline.

## Test plan
- LANES=8, 64-byte frame, no error, full=0 → 8 data words; word0 lane0=0xFB with rxc=8'h01; 9th word rxc=8'hff, rxd=64'h07070707070707fd; stat_frames=1.
- LANES=8, 61-byte frame → 8th word rxc=8'he0, lanes 5..7 = FD,07,07; no 9th word.
- LANES=4, 10-byte frame with gmii_er on byte 6 → lane 1 of word1 = 0xFE with ctrl; final word lane2=FE, lane3=FD, rxc=4'hc; stat_errors=1.
- xgmii_full=1 during word 2 of a 64-byte frame, released after gmii_dv falls → no further data writes; one word rxc=8'hff, rxd=64'h070707070707fdfe; stat_drops=1.
- Reset asserted mid-frame with gmii_dv held high 20 cycles after reset → no writes until gmii_dv low; the next frame is emitted normally.
- FRAME_MAX_BIT_WIDTH=6, 80-byte frame → truncated at 63 bytes with /E//T/; no writes for the remaining bytes; stat_errors=1.
